// File: rtl/fwd_sel_stage_pkg.sv
// Shared constants for the ID->EXE operand-select stage: widths and the
// 3-bit select codes understood by the EXE operand muxes.
package fwd_sel_stage_pkg;

   localparam int RA_W  = 5;
   localparam int CNT_W = 16;

   typedef logic [2:0] sel_t;

   localparam sel_t SEL_RF      = 3'b000;
   localparam sel_t SEL_MEM_ALU = 3'b001;
   localparam sel_t SEL_WB_ALU  = 3'b010;
   localparam sel_t SEL_WB_LD   = 3'b011;
   localparam sel_t SEL_RSVD    = 3'b100;
   localparam sel_t SEL_IMM     = 3'b101;

   // Even parity over a select code, for downstream integrity checking.
   function automatic logic sel_parity(input sel_t sel);
      return ^sel;
   endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Per-operand forwarding select: picks where one EXE operand comes from,
// given the producers currently in EX and MEM.
module fwd_sel_calc #(
   parameter int RA_W = fwd_sel_stage_pkg::RA_W
) (
   input  logic [RA_W-1:0] r,
   input  logic            use_reg,
   input  logic            use_imm,
   input  logic            ex_wreg,
   input  logic            ex_m2reg,
   input  logic [RA_W-1:0] ex_rn,
   input  logic            mem_wreg,
   input  logic            mem_m2reg,
   input  logic [RA_W-1:0] mem_rn,
   output logic [2:0]      sel
);
   import fwd_sel_stage_pkg::*;

   // Priority select: immediate, then r0/unused, then youngest producer (EX) before MEM.
   // A load in EX cannot forward yet; that case is resolved by the load-use stall.
   always_comb begin
      sel = SEL_RF;
      if (use_imm) begin
         sel = SEL_IMM;
      end else if (!use_reg || (r == {RA_W{1'b0}})) begin
         sel = SEL_RF;
      end else if (ex_wreg && !ex_m2reg && (ex_rn == r)) begin
         sel = SEL_MEM_ALU;
      end else if (mem_wreg && (mem_rn == r)) begin
         sel = mem_m2reg ? SEL_WB_LD : SEL_WB_ALU;
      end else begin
         sel = SEL_RF;
      end
   end

endmodule

// File: rtl/fwd_sel_stage.sv
// ID/EX boundary: registers operand-select codes, detects load-use hazards,
// honours multi-cycle EXE hold and branch flush, and counts stall cycles.
module fwd_sel_stage #(
   parameter int RA_W  = fwd_sel_stage_pkg::RA_W,
   parameter int CNT_W = fwd_sel_stage_pkg::CNT_W
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_use_imm,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [RA_W-1:0]  ex_rn,
   input  logic             mem_wreg,
   input  logic             mem_m2reg,
   input  logic [RA_W-1:0]  mem_rn,
   input  logic             flush,
   input  logic             ex_busy,
   output logic             stall,
   output logic             e_valid,
   output logic [2:0]       e_sel_a,
   output logic [2:0]       e_sel_b,
   output logic [CNT_W-1:0] stall_cnt
);
   import fwd_sel_stage_pkg::*;

   sel_t             sel_a_s;
   sel_t             sel_b_s;
   logic             load_use_s;
   logic             flush_pend_r;
   logic             e_valid_r;
   sel_t             e_sel_a_r;
   sel_t             e_sel_b_r;
   logic [CNT_W-1:0] stall_cnt_r;

   fwd_sel_calc #(.RA_W(RA_W)) u_calc_a (
      .r(id_rs), .use_reg(id_use_rs), .use_imm(1'b0),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
      .sel(sel_a_s)
   );

   fwd_sel_calc #(.RA_W(RA_W)) u_calc_b (
      .r(id_rt), .use_reg(id_use_rt), .use_imm(id_use_imm),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
      .sel(sel_b_s)
   );

   // Load in EX feeding an operand of the ID instruction; data is not ready until WB.
   always_comb begin
      load_use_s = id_valid && ex_wreg && ex_m2reg && (ex_rn != {RA_W{1'b0}}) &&
                   ((id_use_rs && (ex_rn == id_rs)) ||
                    (id_use_rt && !id_use_imm && (ex_rn == id_rt)));
      stall      = ex_busy || (load_use_s && !flush && !flush_pend_r);
   end

   // ID/EX register; a flush arriving during a hold is parked in flush_pend_r.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         e_valid_r    <= 1'b0;
         e_sel_a_r    <= SEL_RF;
         e_sel_b_r    <= SEL_RF;
         flush_pend_r <= 1'b0;
      end else if (ex_busy) begin
         if (flush) begin
            flush_pend_r <= 1'b1;
         end else begin
            flush_pend_r <= flush_pend_r;
         end
      end else if (flush || flush_pend_r) begin
         e_valid_r    <= 1'b0;
         e_sel_a_r    <= SEL_RF;
         e_sel_b_r    <= SEL_RF;
         flush_pend_r <= 1'b0;
      end else if (load_use_s) begin
         e_valid_r <= 1'b0;
         e_sel_a_r <= SEL_RF;
         e_sel_b_r <= SEL_RF;
      end else begin
         e_valid_r <= id_valid;
         e_sel_a_r <= id_valid ? sel_a_s : SEL_RF;
         e_sel_b_r <= id_valid ? sel_b_s : SEL_RF;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign e_valid   = e_valid_r;
   assign e_sel_a   = e_sel_a_r;
   assign e_sel_b   = e_sel_b_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fwd_sel_stage.sv
// Scoreboard bench for fwd_sel_stage: directed hazard/flush/hold scenarios
// followed by a randomised forwarding phase against a small reference model.
module tb_fwd_sel_stage;

   logic        clock;
   logic        resetn;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        id_use_imm;
   logic        ex_wreg;
   logic        ex_m2reg;
   logic [4:0]  ex_rn;
   logic        mem_wreg;
   logic        mem_m2reg;
   logic [4:0]  mem_rn;
   logic        flush;
   logic        ex_busy;
   logic        stall;
   logic        e_valid;
   logic [2:0]  e_sel_a;
   logic [2:0]  e_sel_b;
   logic [15:0] stall_cnt;

   typedef struct {
      string       tag;
      logic        v;
      logic [2:0]  a;
      logic [2:0]  b;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [15:0] cnt_m;

   fwd_sel_stage dut (
      .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_imm(id_use_imm),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
      .flush(flush), .ex_busy(ex_busy), .stall(stall), .e_valid(e_valid),
      .e_sel_a(e_sel_a), .e_sel_b(e_sel_b), .stall_cnt(stall_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic id_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic uimm);
      id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_use_imm = uimm;
   endtask

   task automatic ex_in(input logic w, input logic l, input logic [4:0] rn);
      ex_wreg = w; ex_m2reg = l; ex_rn = rn;
   endtask

   task automatic mem_in(input logic w, input logic l, input logic [4:0] rn);
      mem_wreg = w; mem_m2reg = l; mem_rn = rn;
   endtask

   // Called just after a negedge with inputs applied; checks stall, scoreboards the EX result.
   task automatic cyc(input string tag, input logic x_stall, input logic x_v,
                      input logic [2:0] x_a, input logic [2:0] x_b, input logic [15:0] x_cnt);
      exp_t e;
      #1;
      check_val({tag, "_stall"}, 32'(stall), 32'(x_stall));
      e.tag = tag; e.v = x_v; e.a = x_a; e.b = x_b; e.cnt = x_cnt;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_val({e.tag, "_valid"}, 32'(e_valid), 32'(e.v));
         check_val({e.tag, "_sel_a"}, 32'(e_sel_a), 32'(e.a));
         check_val({e.tag, "_sel_b"}, 32'(e_sel_b), 32'(e.b));
         check_val({e.tag, "_cnt"}, 32'(stall_cnt), 32'(e.cnt));
      end
      @(negedge clock);
   endtask

   function automatic logic [2:0] m_sel(input logic [4:0] r, input logic u, input logic imm);
      if (imm) return 3'b101;
      if (!u || r == 5'd0) return 3'b000;
      if (ex_wreg && !ex_m2reg && ex_rn == r) return 3'b001;
      if (mem_wreg && mem_rn == r) return mem_m2reg ? 3'b011 : 3'b010;
      return 3'b000;
   endfunction

   initial begin
      logic lu;
      resetn = 1'b0; flush = 1'b0; ex_busy = 1'b0;
      id_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      ex_in(1'b0, 1'b0, 5'd0);
      mem_in(1'b0, 1'b0, 5'd0);
      #2;
      check_val("rst_stall", 32'(stall), 32'd0);
      check_val("rst_valid", 32'(e_valid), 32'd0);
      check_val("rst_sel_a", 32'(e_sel_a), 32'd0);
      check_val("rst_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clock);
      resetn = 1'b1;

      // EX-stage ALU forward to A
      ex_in(1'b1, 1'b0, 5'd3); id_in(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0);
      cyc("ex_fwd", 1'b0, 1'b1, 3'b001, 3'b000, 16'd1 - 16'd1);
      // load-use: bubble, then load data from WB
      ex_in(1'b1, 1'b1, 5'd3);
      cyc("lu_bubble", 1'b1, 1'b0, 3'b000, 3'b000, 16'd1);
      ex_in(1'b0, 1'b0, 5'd0); mem_in(1'b1, 1'b1, 5'd3);
      cyc("lu_wb_ld", 1'b0, 1'b1, 3'b011, 3'b000, 16'd1);
      // EX beats MEM; immediate overrides; MEM-only ALU forward
      ex_in(1'b1, 1'b0, 5'd7); mem_in(1'b1, 1'b0, 5'd7); id_in(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0);
      cyc("ex_over_mem", 1'b0, 1'b1, 3'b000, 3'b001, 16'd1);
      id_in(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1);
      cyc("imm_b", 1'b0, 1'b1, 3'b000, 3'b101, 16'd1);
      ex_in(1'b1, 1'b0, 5'd8); id_in(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0);
      cyc("mem_alu", 1'b0, 1'b1, 3'b000, 3'b010, 16'd1);
      // r0 never forwarded nor stalled on
      ex_in(1'b1, 1'b1, 5'd0); mem_in(1'b1, 1'b0, 5'd0); id_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      cyc("r0", 1'b0, 1'b1, 3'b000, 3'b000, 16'd1);
      // load into rt hidden by immediate; invalid ID never stalls
      ex_in(1'b1, 1'b1, 5'd6); mem_in(1'b0, 1'b0, 5'd0); id_in(1'b1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1);
      cyc("imm_no_lu", 1'b0, 1'b1, 3'b000, 3'b101, 16'd1);
      id_in(1'b0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc("inv_no_lu", 1'b0, 1'b0, 3'b000, 3'b000, 16'd1);
      // multi-cycle hold with flush pulsed mid-hold
      ex_in(1'b1, 1'b0, 5'd9); id_in(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc("pre_busy", 1'b0, 1'b1, 3'b001, 3'b000, 16'd1);
      ex_in(1'b0, 1'b0, 5'd0); id_in(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0); ex_busy = 1'b1;
      cyc("busy1", 1'b1, 1'b1, 3'b001, 3'b000, 16'd2);
      flush = 1'b1;
      cyc("busy2", 1'b1, 1'b1, 3'b001, 3'b000, 16'd3);
      flush = 1'b0;
      cyc("busy3", 1'b1, 1'b1, 3'b001, 3'b000, 16'd4);
      ex_busy = 1'b0; ex_in(1'b1, 1'b0, 5'd9); id_in(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc("pend_flush", 1'b0, 1'b0, 3'b000, 3'b000, 16'd4);
      // flush masks a load-use stall
      ex_in(1'b1, 1'b1, 5'd3); id_in(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0); flush = 1'b1;
      cyc("flush_lu", 1'b0, 1'b0, 3'b000, 3'b000, 16'd4);
      flush = 1'b0;
      // async reset in the middle of a load-use stall
      ex_in(1'b1, 1'b0, 5'd3); id_in(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0);
      cyc("pre_rst", 1'b0, 1'b1, 3'b001, 3'b001, 16'd4);
      ex_in(1'b1, 1'b1, 5'd3);
      #1;
      check_val("midrst_stall", 32'(stall), 32'd1);
      resetn = 1'b0;
      #1;
      check_val("midrst_valid", 32'(e_valid), 32'd0);
      check_val("midrst_sel_a", 32'(e_sel_a), 32'd0);
      check_val("midrst_sel_b", 32'(e_sel_b), 32'd0);
      check_val("midrst_cnt", 32'(stall_cnt), 32'd0);
      check_val("midrst_stall_in_rst", 32'(stall), 32'd1);
      @(negedge clock);
      resetn = 1'b1;

      // randomised forwarding against the reference model
      cnt_m = 16'd0;
      for (int i = 0; i < 40; i++) begin
         id_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         ex_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
         mem_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
         lu = id_valid && ex_wreg && ex_m2reg && ex_rn != 5'd0 &&
              ((id_use_rs && ex_rn == id_rs) || (id_use_rt && !id_use_imm && ex_rn == id_rt));
         cnt_m = cnt_m + 16'(lu);
         if (lu || !id_valid)
            cyc($sformatf("rnd%0d", i), lu, 1'b0, 3'b000, 3'b000, cnt_m);
         else
            cyc($sformatf("rnd%0d", i), 1'b0, 1'b1, m_sel(id_rs, id_use_rs, 1'b0),
                m_sel(id_rt, id_use_rt, id_use_imm), cnt_m);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
